// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped, read-only, one-word-per-line cache controller.
// Drives the shared index and write strobes of external valid/tag/data RAMs
// (all with a 1-cycle registered read), compares tags, and runs a single
// outstanding refill to memory on a miss. Whole-cache invalidate is issued
// through ValidRamReset.
//
// Optional build macro: CACHE_STAT_EN adds 32-bit HitCount/MissCount outputs.

module cache_ctrl #(
   parameter  int ADDR_W  = 32,
   parameter  int INDEX_W = 6,
   parameter  int DATA_W  = 32,
   localparam int TAG_W   = ADDR_W - INDEX_W - 2
) (
   input  logic               Clk,
   input  logic               Reset,
   // CPU side
   input  logic               CpuReq,
   input  logic [ADDR_W-1:0]  CpuAddr,
   output logic               CpuReady,
   output logic [DATA_W-1:0]  CpuRdata,
   input  logic               Flush,
   // memory side
   output logic               MemReq,
   output logic [ADDR_W-1:0]  MemAddr,
   input  logic               MemAck,
   input  logic [DATA_W-1:0]  MemRdata,
   // storage arrays
   output logic [INDEX_W-1:0] RamAddress,
   output logic               ValidWrite,
   output logic               ValidIn,
   output logic               ValidRamReset,
   input  logic               ValidOut,
   output logic               TagWrite,
   output logic [TAG_W-1:0]   TagIn,
   input  logic [TAG_W-1:0]   TagOut,
   output logic               DataWrite,
   output logic [DATA_W-1:0]  DataIn,
   input  logic [DATA_W-1:0]  DataOut
`ifdef CACHE_STAT_EN
   ,
   output logic [31:0]        HitCount,
   output logic [31:0]        MissCount
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      FILL,
      FLUSH
   } state_t;

   state_t              state;
   state_t              state_next;

   // Word address of the accepted request: {tag, index}.
   logic [ADDR_W-3:0]   word_addr;
   logic [ADDR_W-3:0]   word_addr_next;
   logic [DATA_W-1:0]   fill_data;
   logic [DATA_W-1:0]   fill_data_next;
   logic                pending_flush;
   logic                pending_flush_next;
   logic                fill_we;
   logic                fill_we_next;

   logic                cpu_ready_next;
   logic [DATA_W-1:0]   cpu_rdata_next;
   logic                mem_req_next;
   logic [ADDR_W-1:0]   mem_addr_next;

   logic [TAG_W-1:0]    tag_q;
   logic [INDEX_W-1:0]  index_q;
   logic                hit;

   // Byte-offset bits never select anything in a one-word line.
   logic                unused_byte_offset;
   assign unused_byte_offset = ^CpuAddr[1:0];

   assign tag_q   = word_addr[ADDR_W-3:INDEX_W];
   assign index_q = word_addr[INDEX_W-1:0];

   // In LOOKUP the RAM outputs belong to the latched index.
   assign hit = ValidOut && (TagOut == tag_q);

   // The RAMs register their address on the accept edge, so IDLE presents the
   // live CPU index; afterwards the latched index keeps it stable.
   assign RamAddress = (state == IDLE) ? CpuAddr[INDEX_W+1:2] : index_q;

   // Clearing during reset lets the valid array come up empty without a FLUSH.
   assign ValidRamReset = Reset | (state == FLUSH);

   // A single strobe writes all three arrays in FILL.
   assign ValidWrite = fill_we;
   assign TagWrite   = fill_we;
   assign DataWrite  = fill_we;
   assign ValidIn    = 1'b1;
   assign TagIn      = tag_q;
   assign DataIn     = fill_data;

   // State register.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking (<=) so every register
         // samples pre-edge values regardless of statement order.
         state <= state_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can leave one
      // unassigned and infer a latch.
      state_next         = state;
      word_addr_next     = word_addr;
      fill_data_next     = fill_data;
      pending_flush_next = pending_flush;
      fill_we_next       = 1'b0;
      cpu_ready_next     = 1'b0;
      cpu_rdata_next     = CpuRdata;
      mem_req_next       = MemReq;
      mem_addr_next      = MemAddr;

      unique case (state)
         IDLE: begin
            if (Flush || pending_flush) begin
               state_next = FLUSH;
            end else if (CpuReq && !CpuReady) begin
               // CpuReq is still high in the CpuReady cycle after a hit; that
               // cycle must not be taken as a fresh request.
               word_addr_next = CpuAddr[ADDR_W-1:2];
               state_next     = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit) begin
               cpu_ready_next = 1'b1;
               cpu_rdata_next = DataOut;
               state_next     = IDLE;
            end else begin
               mem_req_next  = 1'b1;
               mem_addr_next = {word_addr, 2'b00};
               state_next    = MISS;
            end
         end
         MISS: begin
            if (MemAck) begin
               fill_data_next = MemRdata;
               mem_req_next   = 1'b0;
               cpu_ready_next = 1'b1;
               cpu_rdata_next = MemRdata;
               fill_we_next   = 1'b1;
               state_next     = FILL;
            end
         end
         FILL: begin
            state_next = IDLE;
         end
         FLUSH: begin
            pending_flush_next = 1'b0;
            state_next         = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // A flush during an access waits for it to finish, fill write included.
      if (Flush && (state == LOOKUP || state == MISS || state == FILL)) begin
         pending_flush_next = 1'b1;
      end
   end

   // Request/refill registers and registered outputs.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         word_addr     <= '0;
         fill_data     <= '0;
         pending_flush <= 1'b0;
         fill_we       <= 1'b0;
         CpuReady      <= 1'b0;
         CpuRdata      <= '0;
         MemReq        <= 1'b0;
         MemAddr       <= '0;
      end else begin
         word_addr     <= word_addr_next;
         fill_data     <= fill_data_next;
         pending_flush <= pending_flush_next;
         fill_we       <= fill_we_next;
         CpuReady      <= cpu_ready_next;
         CpuRdata      <= cpu_rdata_next;
         MemReq        <= mem_req_next;
         MemAddr       <= mem_addr_next;
      end
   end

`ifdef CACHE_STAT_EN
   // Hit/miss statistics, counted at the LOOKUP decision; Flush leaves them.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         HitCount  <= '0;
         MissCount <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            HitCount <= HitCount + 32'd1;
         end else begin
            MissCount <= MissCount + 32'd1;
         end
      end
   end
`endif

   // The refill request is exactly the MISS state, and the array write is
   // exactly the FILL state.
   a_memreq_in_miss : assert property (@(posedge Clk) disable iff (Reset)
      MemReq == (state == MISS));
   a_write_in_fill : assert property (@(posedge Clk) disable iff (Reset)
      fill_we == (state == FILL));

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl. Models the three
// registered-read storage arrays and answers refills inline from the stimulus.
// Build with CACHE_STAT_EN defined to also check the hit/miss counters.

module tb_cache_ctrl;

   localparam int ADDR_W  = 32;
   localparam int INDEX_W = 6;
   localparam int DATA_W  = 32;
   localparam int TAG_W   = ADDR_W - INDEX_W - 2;
   localparam int LINES   = 2 ** INDEX_W;

   logic               Clk = 1'b0;
   logic               Reset = 1'b1;
   logic               CpuReq = 1'b0;
   logic [ADDR_W-1:0]  CpuAddr = '0;
   logic               CpuReady;
   logic [DATA_W-1:0]  CpuRdata;
   logic               Flush = 1'b0;
   logic               MemReq;
   logic [ADDR_W-1:0]  MemAddr;
   logic               MemAck = 1'b0;
   logic [DATA_W-1:0]  MemRdata = '0;
   logic [INDEX_W-1:0] RamAddress;
   logic               ValidWrite;
   logic               ValidIn;
   logic               ValidRamReset;
   logic               ValidOut = 1'b0;
   logic               TagWrite;
   logic [TAG_W-1:0]   TagIn;
   logic [TAG_W-1:0]   TagOut = '0;
   logic               DataWrite;
   logic [DATA_W-1:0]  DataIn;
   logic [DATA_W-1:0]  DataOut = '0;
`ifdef CACHE_STAT_EN
   logic [31:0]        HitCount;
   logic [31:0]        MissCount;
`endif

   int compared   = 0;
   int mismatched = 0;

   cache_ctrl #(
      .ADDR_W  (ADDR_W),
      .INDEX_W (INDEX_W),
      .DATA_W  (DATA_W)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .CpuReq        (CpuReq),
      .CpuAddr       (CpuAddr),
      .CpuReady      (CpuReady),
      .CpuRdata      (CpuRdata),
      .Flush         (Flush),
      .MemReq        (MemReq),
      .MemAddr       (MemAddr),
      .MemAck        (MemAck),
      .MemRdata      (MemRdata),
      .RamAddress    (RamAddress),
      .ValidWrite    (ValidWrite),
      .ValidIn       (ValidIn),
      .ValidRamReset (ValidRamReset),
      .ValidOut      (ValidOut),
      .TagWrite      (TagWrite),
      .TagIn         (TagIn),
      .TagOut        (TagOut),
      .DataWrite     (DataWrite),
      .DataIn        (DataIn),
      .DataOut       (DataOut)
`ifdef CACHE_STAT_EN
      ,
      .HitCount      (HitCount),
      .MissCount     (MissCount)
`endif
   );

   always #5 Clk = ~Clk;

   // Storage arrays: registered read, synchronous clear of the valid array.
   logic              valid_mem [LINES];
   logic [TAG_W-1:0]  tag_mem   [LINES];
   logic [DATA_W-1:0] data_mem  [LINES];

   always @(posedge Clk) begin
      if (ValidRamReset) begin
         for (int i = 0; i < LINES; i++) valid_mem[i] <= 1'b0;
         ValidOut <= 1'b0;
      end else begin
         if (ValidWrite) valid_mem[RamAddress] <= ValidIn;
         ValidOut <= valid_mem[RamAddress];
      end
      if (TagWrite) tag_mem[RamAddress] <= TagIn;
      TagOut <= tag_mem[RamAddress];
      if (DataWrite) data_mem[RamAddress] <= DataIn;
      DataOut <= data_mem[RamAddress];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One CPU read. Memory answers with 'word' after 'waits' idle MISS cycles.
   // Optionally pulses Flush in the first MISS cycle.
   task automatic cpu_read(input string tag, input logic [31:0] addr, input logic [31:0] word,
                           input int waits, input bit exp_miss, input bit flush_in_miss);
      int k;
      int req_cycles;
      bit saw_req;
      bit done;
      int lat;
      k = 0; req_cycles = 0; saw_req = 1'b0; done = 1'b0; lat = 0;
      @(negedge Clk);
      CpuReq  = 1'b1;
      CpuAddr = addr;
      while (!done && k < 40) begin
         @(negedge Clk);
         k++;
         Flush  = 1'b0;
         MemAck = 1'b0;
         if (MemReq) begin
            if (!saw_req) begin
               check($sformatf("%s_mem_addr", tag), 64'(MemAddr), 64'({addr[31:2], 2'b00}));
               if (flush_in_miss) Flush = 1'b1;
            end
            saw_req = 1'b1;
            req_cycles++;
            if (req_cycles == waits + 1) begin
               MemAck   = 1'b1;
               MemRdata = word;
            end
         end
         if (CpuReady) begin
            done = 1'b1;
            lat  = k;
            check($sformatf("%s_rdata", tag), 64'(CpuRdata), 64'(word));
            check($sformatf("%s_data_we", tag), 64'(DataWrite), 64'(exp_miss));
            check($sformatf("%s_tag_we", tag), 64'(TagWrite), 64'(exp_miss));
            check($sformatf("%s_valid_we", tag), 64'(ValidWrite), 64'(exp_miss));
            if (exp_miss) begin
               check($sformatf("%s_tag_in", tag), 64'(TagIn), 64'(addr[31:8]));
               check($sformatf("%s_data_in", tag), 64'(DataIn), 64'(word));
               check($sformatf("%s_valid_in", tag), 64'(ValidIn), 64'd1);
               check($sformatf("%s_ram_addr", tag), 64'(RamAddress), 64'(addr[7:2]));
            end
            CpuReq = 1'b0;
         end
      end
      check($sformatf("%s_ready_seen", tag), 64'(done), 64'd1);
      check($sformatf("%s_memreq", tag), 64'(saw_req), 64'(exp_miss));
      check($sformatf("%s_latency", tag), 64'(lat), exp_miss ? 64'(3 + waits) : 64'd2);
      CpuReq = 1'b0;
      Flush  = 1'b0;
      MemAck = 1'b0;
   endtask

   // Counts cycles with ValidRamReset high over the next n cycles.
   task automatic count_flush_cycles(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge Clk);
         if (ValidRamReset) cnt++;
      end
   endtask

   initial begin
      int cnt;
      int busy;
      bit got_req;

      // Reset state
      repeat (3) @(negedge Clk);
      check("rst_cpu_ready", 64'(CpuReady), 64'd0);
      check("rst_cpu_rdata", 64'(CpuRdata), 64'd0);
      check("rst_mem_req", 64'(MemReq), 64'd0);
      check("rst_mem_addr", 64'(MemAddr), 64'd0);
      check("rst_writes", 64'({DataWrite, TagWrite, ValidWrite}), 64'd0);
      check("rst_vram_reset", 64'(ValidRamReset), 64'd1);
      Reset = 1'b0;
      #1 check("rel_vram_reset", 64'(ValidRamReset), 64'd0);
`ifdef CACHE_STAT_EN
      check("rst_hit_count", 64'(HitCount), 64'd0);
      check("rst_miss_count", 64'(MissCount), 64'd0);
`endif

      // Cold miss with two memory wait cycles, then a hit
      cpu_read("miss_104", 32'h0000_0104, 32'hDEAD_BEEF, 2, 1'b1, 1'b0);
      cpu_read("hit_104", 32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);

      // Same index, different tag: evicts, and the old line misses again
      cpu_read("miss_1104", 32'h0000_1104, 32'h1234_5678, 1, 1'b1, 1'b0);
      cpu_read("hit_1104", 32'h0000_1104, 32'h1234_5678, 0, 1'b0, 1'b0);
      cpu_read("evict_104", 32'h0000_0104, 32'hDEAD_BEEF, 0, 1'b1, 1'b0);

      // Top index with tag zero
      cpu_read("miss_0fc", 32'h0000_00FC, 32'hA5A5_0FF0, 3, 1'b1, 1'b0);
      cpu_read("hit_0fc", 32'h0000_00FC, 32'hA5A5_0FF0, 0, 1'b0, 1'b0);

      // Flush in IDLE: exactly one clear cycle, all lines invalid afterwards
      @(negedge Clk);
      Flush = 1'b1;
      #1 check("flush_idle_pre", 64'(ValidRamReset), 64'd0);
      @(negedge Clk);
      Flush = 1'b0;
      check("flush_idle_on", 64'(ValidRamReset), 64'd1);
      @(negedge Clk);
      check("flush_idle_off", 64'(ValidRamReset), 64'd0);
      cpu_read("post_flush_104", 32'h0000_0104, 32'hCAFE_F00D, 0, 1'b1, 1'b0);
      cpu_read("post_flush_0fc", 32'h0000_00FC, 32'hA5A5_0FF0, 0, 1'b1, 1'b0);

      // Flush during MISS: access completes, then one flush cycle
      cpu_read("flush_in_miss", 32'h0000_2208, 32'h0BAD_CAFE, 2, 1'b1, 1'b1);
      count_flush_cycles(4, cnt);
      check("deferred_flush_cycles", 64'(cnt), 64'd1);
      cpu_read("after_deferred_flush", 32'h0000_2208, 32'h0BAD_CAFE, 0, 1'b1, 1'b0);

      // Reset while MemReq is high; a late MemAck must be ignored
      @(negedge Clk);
      CpuReq  = 1'b1;
      CpuAddr = 32'h0000_0104;
      got_req = 1'b0;
      for (int i = 0; i < 10 && !got_req; i++) begin
         @(negedge Clk);
         if (MemReq) got_req = 1'b1;
      end
      check("pre_reset_memreq", 64'(got_req), 64'd1);
      #2 Reset = 1'b1;
      #1 check("async_reset_memreq", 64'(MemReq), 64'd0);
      check("async_reset_ready", 64'(CpuReady), 64'd0);
      check("async_reset_vram", 64'(ValidRamReset), 64'd1);
      CpuReq = 1'b0;
      @(negedge Clk);
      Reset = 1'b0;
`ifdef CACHE_STAT_EN
      check("reset_hit_count", 64'(HitCount), 64'd0);
      check("reset_miss_count", 64'(MissCount), 64'd0);
`endif
      MemAck   = 1'b1;
      MemRdata = 32'hFFFF_FFFF;
      busy = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         MemAck = 1'b0;
         if (CpuReady || DataWrite || MemReq) busy++;
      end
      check("late_ack_ignored", 64'(busy), 64'd0);

      cpu_read("post_reset_miss", 32'h0000_0104, 32'h55AA_33CC, 1, 1'b1, 1'b0);
      cpu_read("post_reset_hit", 32'h0000_0104, 32'h55AA_33CC, 0, 1'b0, 1'b0);
`ifdef CACHE_STAT_EN
      check("final_hit_count", 64'(HitCount), 64'd1);
      check("final_miss_count", 64'(MissCount), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
